// File: rtl/seg_pkg.sv
// seg_pkg
//  Shared constants and types for the 3-digit multiplexed 7-segment scanner.
//  Segment patterns are {a,b,c,d,e,f,g}, active-low. Digit enables are
//  {SE0,SE1,SE2}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [2:0] SE_OFF  = 3'b111;
    localparam logic [2:0] SE_DIG0 = 3'b011;
    localparam logic [2:0] SE_DIG1 = 3'b101;
    localparam logic [2:0] SE_DIG2 = 3'b110;

    // [4] = blank flag, [3:0] = hex value
    localparam logic [4:0] BLANK_VAL = 5'b10000;

    // Digit-slot state, one-hot encoded.
    typedef enum logic [2:0] {
        DIG0 = 3'b001,
        DIG1 = 3'b010,
        DIG2 = 3'b100
    } idx_e;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
//  Combinational 4-bit hex to 7-segment decoder (active-low outputs).
//  Ports:
//    hex_i  in  4  hex value 0..F
//    seg_o  out 7  {a,b,c,d,e,f,g}, active-low
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//  Scan scheduler for a 3-digit multiplexed 7-segment display. Each digit
//  gets a slot of SCAN_DIV clocks; the first DEAD_CYC clocks of every slot
//  are dark to avoid ghosting. Digit values are written into a shadow copy
//  and copied to the displayed (active) copy only at the end of a frame, so
//  a frame never mixes old and new digits.
//  Ports:
//    clk         in   1  system clock
//    reset       in   1  asynchronous, active-high reset
//    enable      in   1  1 = scanning, 0 = dark with scan held at slot 0
//    wr_en       in   1  single-cycle shadow write strobe
//    wr_digit    in   2  target digit 0..2 (3 is ignored)
//    wr_data     in   5  [4]=blank, [3:0]=hex value
//    SE0..SE2    out  1  digit enables, active-low
//    seg         out  7  {a,b,c,d,e,f,g}, active-low
//    frame_tick  out  1  one-cycle pulse after a shadow->active commit
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [15:0] DEAD_CYC = 16'd500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [1:0] wr_digit,
    input  logic [4:0] wr_data,
    output logic       SE0,
    output logic       SE1,
    output logic       SE2,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam logic [15:0] CNT_MAX = SCAN_DIV - 16'd1;

    logic [15:0] cnt_q, cnt_d;
    idx_e        idx_q, idx_d;
    logic [4:0]  shadow_q [3];
    logic [4:0]  shadow_d [3];
    logic [4:0]  active_q [3];
    logic [4:0]  active_d [3];
    logic [2:0]  se_q, se_d;
    logic [6:0]  seg_q, seg_d;
    logic        tick_q, tick_d;

    logic        wrap;
    logic        commit;
    logic        lit_window;
    logic [4:0]  cur_val;
    logic [2:0]  cur_se;
    logic [6:0]  cur_seg;

    assign wrap   = (cnt_q == CNT_MAX);
    assign commit = enable && (idx_q == DIG2) && wrap;

    // cnt >= DEAD_CYC, written as cnt+1 > DEAD_CYC in 17 bits so the
    // expression stays well-formed when DEAD_CYC is zero.
    assign lit_window = ((17'(cnt_q) + 17'd1) > 17'(DEAD_CYC));

    // Per-digit shadow/active storage. The commit (and the follow-while-
    // disabled path) copies shadow_d, so a write landing on the commit
    // cycle is included in the frame that follows.
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
        assign shadow_d[gi] = (wr_en && (wr_digit == 2'(gi))) ? wr_data : shadow_q[gi];
        assign active_d[gi] = (!enable || commit) ? shadow_d[gi] : active_q[gi];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_q[gi] <= BLANK_VAL;
                active_q[gi] <= BLANK_VAL;
            end else begin
                shadow_q[gi] <= shadow_d[gi];
                active_q[gi] <= active_d[gi];
            end
        end
    end

    // Slot FSM and prescaler next state.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!enable) begin
            cnt_d = '0;
            idx_d = DIG0;
        end else if (wrap) begin
            cnt_d = '0;
            case (idx_q)
                DIG0:    idx_d = DIG1;
                DIG1:    idx_d = DIG2;
                DIG2:    idx_d = DIG0;
                default: idx_d = DIG0;
            endcase
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Value and enable pattern for the slot currently being scanned.
    always_comb begin
        cur_val = BLANK_VAL;
        cur_se  = SE_OFF;
        case (idx_q)
            DIG0: begin
                cur_val = active_q[0];
                cur_se  = SE_DIG0;
            end
            DIG1: begin
                cur_val = active_q[1];
                cur_se  = SE_DIG1;
            end
            DIG2: begin
                cur_val = active_q[2];
                cur_se  = SE_DIG2;
            end
            default: begin
                cur_val = BLANK_VAL;
                cur_se  = SE_OFF;
            end
        endcase
    end

    seg_hex_decode u_dec (
        .hex_i (cur_val[3:0]),
        .seg_o (cur_seg)
    );

    // Output registers. Only one pattern is ever loaded per cycle, so at
    // most one enable is low even across a slot change.
    always_comb begin
        se_d   = SE_OFF;
        seg_d  = SEG_OFF;
        tick_d = commit;
        if (enable && lit_window && !cur_val[4]) begin
            se_d  = cur_se;
            seg_d = cur_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= DIG0;
            se_q   <= SE_OFF;
            seg_q  <= SEG_OFF;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            se_q   <= se_d;
            seg_q  <= seg_d;
            tick_q <= tick_d;
        end
    end

    assign {SE0, SE1, SE2} = se_q;
    assign seg             = seg_q;
    assign frame_tick      = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl. Instance A uses SCAN_DIV=8, DEAD_CYC=2;
// instance B uses SCAN_DIV=8, DEAD_CYC=0. Stimulus inputs are shared; the
// instance not under test is held in reset.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       enable, wr_en;
    logic [1:0] wr_digit;
    logic [4:0] wr_data;

    logic       a_se0, a_se1, a_se2, a_tick;
    logic [6:0] a_seg;
    logic       b_se0, b_se1, b_se2, b_tick;
    logic [6:0] b_seg;

    logic       sel;
    logic [2:0] se_obs;
    logic [6:0] seg_obs;
    logic       tick_obs;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int         pos;
        logic [1:0] dig;
        logic [4:0] dat;
    } wr_t;
    wr_t wq[$];

    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S1   = 7'b1001111;
    localparam logic [6:0] S2   = 7'b0010010;
    localparam logic [6:0] S3   = 7'b0000110;
    localparam logic [6:0] S5   = 7'b0100100;
    localparam logic [6:0] S7   = 7'b0001111;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SF   = 7'b0111000;
    localparam logic [6:0] SOFF = 7'h7F;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(16'd8), .DEAD_CYC(16'd2)) dut_a (
        .clk(clk), .reset(rst_a), .enable(enable), .wr_en(wr_en),
        .wr_digit(wr_digit), .wr_data(wr_data),
        .SE0(a_se0), .SE1(a_se1), .SE2(a_se2), .seg(a_seg), .frame_tick(a_tick)
    );

    seg_scan_ctrl #(.SCAN_DIV(16'd8), .DEAD_CYC(16'd0)) dut_b (
        .clk(clk), .reset(rst_b), .enable(enable), .wr_en(wr_en),
        .wr_digit(wr_digit), .wr_data(wr_data),
        .SE0(b_se0), .SE1(b_se1), .SE2(b_se2), .seg(b_seg), .frame_tick(b_tick)
    );

    always_comb begin
        se_obs   = sel ? {b_se0, b_se1, b_se2} : {a_se0, a_se1, a_se2};
        seg_obs  = sel ? b_seg : a_seg;
        tick_obs = sel ? b_tick : a_tick;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, ".se"}, 32'(se_obs), 32'(3'b111));
        chk({tag, ".seg"}, 32'(seg_obs), 32'(7'h7F));
        chk({tag, ".tick"}, 32'(tick_obs), 32'(0));
    endtask

    // Checks one 24-cycle frame starting right after the scan is at slot 0,
    // cnt 0. Sample k shows the state at frame position k-1; sample 24 is
    // the one carrying the commit pulse. After sample k, queued writes with
    // pos==k are driven so they land while the scan sits at position k.
    // A digit expected as 7'h7F is treated as blank.
    task automatic check_frame(input string tag, input int dead,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2);
        logic [6:0] segs [3];
        int         slot, c;
        logic       lit;
        logic [2:0] exp_se;
        logic [6:0] exp_seg;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            slot    = (k - 1) / 8;
            c       = (k - 1) % 8;
            lit     = (c >= dead) && (segs[slot] != 7'h7F);
            exp_se  = !lit ? 3'b111 : (slot == 0) ? 3'b011 : (slot == 1) ? 3'b101 : 3'b110;
            exp_seg = lit ? segs[slot] : 7'h7F;
            chk($sformatf("%s.se[%0d]", tag, k), 32'(se_obs), 32'(exp_se));
            chk($sformatf("%s.seg[%0d]", tag, k), 32'(seg_obs), 32'(exp_seg));
            chk($sformatf("%s.tick[%0d]", tag, k), 32'(tick_obs), 32'(k == 24));
            chk($sformatf("%s.onehot[%0d]", tag, k), 32'($countones(~se_obs) <= 1), 32'(1));
            wr_en = 1'b0;
            foreach (wq[i]) begin
                if (wq[i].pos == k) begin
                    wr_en    = 1'b1;
                    wr_digit = wq[i].dig;
                    wr_data  = wq[i].dat;
                end
            end
        end
        wq.delete();
        $display("frame %s checked", tag);
    endtask

    initial begin
        sel      = 1'b0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        enable   = 1'b1;
        wr_en    = 1'b0;
        wr_digit = 2'd0;
        wr_data  = 5'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk_dark("reset");
        rst_a = 1'b0;

        // First frame after release is blank; writes d0=5, d1=A, d2=0.
        wq.push_back('{pos: 3, dig: 2'd0, dat: 5'h05});
        wq.push_back('{pos: 4, dig: 2'd1, dat: 5'h0A});
        wq.push_back('{pos: 5, dig: 2'd2, dat: 5'h00});
        check_frame("t1_blank", 2, SOFF, SOFF, SOFF);

        // Shows 5/A/0. Mid-frame d1=F stays hidden; commit-cycle d0=3 is taken.
        wq.push_back('{pos: 2,  dig: 2'd1, dat: 5'h0F});
        wq.push_back('{pos: 23, dig: 2'd0, dat: 5'h03});
        check_frame("t2_5A0", 2, S5, SA, S0);

        // Shows 3/F/0. wr_digit=3 must not land anywhere; d2 goes blank.
        wq.push_back('{pos: 5,  dig: 2'd3, dat: 5'h08});
        wq.push_back('{pos: 10, dig: 2'd2, dat: 5'b10101});
        check_frame("t3_3F0", 2, S3, SF, S0);

        check_frame("t4_3F_", 2, S3, SF, SOFF);

        // Enable low mid-slot for 20 cycles with a write to d0.
        repeat (10) @(negedge clk);
        enable = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk_dark($sformatf("t5_off[%0d]", i));
            wr_en    = (i == 5);
            wr_digit = 2'd0;
            wr_data  = 5'h07;
        end
        wr_en  = 1'b0;
        enable = 1'b1;
        check_frame("t5_7F_", 2, S7, SF, SOFF);

        // Asynchronous reset in the middle of lit slot 1.
        repeat (12) @(negedge clk);
        chk("t1_prelit.se", 32'(se_obs), 32'(3'b101));
        chk("t1_prelit.seg", 32'(seg_obs), 32'(SF));
        #2 rst_a = 1'b1;
        #1 chk_dark("t1_async");
        @(negedge clk);
        rst_a = 1'b0;
        check_frame("t1_after", 2, SOFF, SOFF, SOFF);

        // DEAD_CYC=0 instance: load digits while disabled, then scan.
        rst_a  = 1'b1;
        sel    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            wr_en    = 1'b1;
            wr_digit = 2'(d);
            wr_data  = 5'(d + 1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk_dark("t6_off");
        enable = 1'b1;
        check_frame("t6_dead0", 0, S1, S2, S3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
